// File: rtl/passcode_lock_pkg.sv
// Shared state encoding, key codes and helpers for the keypad passcode lock.
package passcode_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT
  } lock_state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the timed lock states; expire flags a count of 1.
module lock_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load)
      cnt_q <= load_val;
    else if (cnt_q != '0)
      cnt_q <= cnt_q - TW'(1);
  end

  assign expire = (cnt_q == TW'(1));

endmodule

// File: rtl/passcode_lock_ctrl.sv
// Keypad passcode lock sequencer: digit entry, compare, unlock/fail/lockout timing.
// Optional ENTRY_TIMEOUT_EN: inactivity timeout in ENTRY using ENTRY_TO_CYC.
module passcode_lock_ctrl #(
  parameter int unsigned PW_LEN       = 4,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned UNLOCK_CYC   = 50_000_000,
  parameter int unsigned FAIL_CYC     = 10_000_000,
  parameter int unsigned LOCKOUT_CYC  = 250_000_000,
  parameter int unsigned ENTRY_TO_CYC = 250_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           key_valid,
  input  logic [3:0]                     key_value,
  input  logic [4*PW_LEN-1:0]            preset_pw,
  output logic [4*PW_LEN-1:0]            entry_digits,
  output logic [PW_LEN-1:0]              entry_mask,
  output logic                           key_ack,
  output logic                           key_err,
  output logic                           unlock,
  output logic                           fail_tone,
  output logic                           alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);
  import passcode_lock_pkg::*;

  localparam int unsigned CW      = $clog2(PW_LEN + 1);
  localparam int unsigned FW      = $clog2(MAX_TRIES + 1);
  localparam int unsigned MAX_CYC = max2(max2(UNLOCK_CYC, FAIL_CYC), max2(LOCKOUT_CYC, ENTRY_TO_CYC));
  // +1 so a *_CYC that is an exact power of two still fits
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  lock_state_t         state_q, state_d;
  logic [4*PW_LEN-1:0] entry_q, entry_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_m1;
  logic [FW-1:0]       fail_q, fail_d, fail_inc;
  logic                ack_d, err_d;
  logic                tmr_load, tmr_expire;
  logic [TW-1:0]       tmr_val;
  logic                is_digit, is_cmd;

  lock_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign is_digit = (key_value <= 4'd9);
  assign is_cmd   = (key_value == KEY_ENTER) || (key_value == KEY_BKSP) || (key_value == KEY_CLR);
  assign cnt_m1   = cnt_q - CW'(1);
  assign fail_inc = fail_q + FW'(1);

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          if (is_digit) begin
            entry_d      = '0;
            entry_d[3:0] = key_value;
            cnt_d        = CW'(1);
            ack_d        = 1'b1;
            state_d      = ST_ENTRY;
          end else if (is_cmd) begin
            err_d = 1'b1;
          end
        end
      end
      ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            if (cnt_q < CW'(PW_LEN)) begin
              for (int unsigned i = 0; i < PW_LEN; i++)
                if (CW'(i) == cnt_q) entry_d[4*i +: 4] = key_value;
              cnt_d = cnt_q + CW'(1);
              ack_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_value == KEY_BKSP) begin
            for (int unsigned i = 0; i < PW_LEN; i++)
              if (CW'(i) == cnt_m1) entry_d[4*i +: 4] = '0;
            cnt_d = cnt_m1;
            ack_d = 1'b1;
            if (cnt_m1 == '0) state_d = ST_IDLE;
          end else if (key_value == KEY_CLR) begin
            entry_d = '0;
            cnt_d   = '0;
            ack_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (key_value == KEY_ENTER) begin
            if (cnt_q == CW'(PW_LEN)) begin
              ack_d   = 1'b1;
              state_d = ST_CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
`ifdef ENTRY_TIMEOUT_EN
        // a key handled on the expiry cycle reloads the timer instead of timing out
        if (tmr_expire && !ack_d && !err_d) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
`endif
      end
      ST_CHECK: begin
        entry_d  = '0;
        cnt_d    = '0;
        tmr_load = 1'b1;
        if (entry_q == preset_pw) begin
          fail_d  = '0;
          tmr_val = TW'(UNLOCK_CYC);
          state_d = ST_OPEN;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == FW'(MAX_TRIES)) begin
            tmr_val = TW'(LOCKOUT_CYC);
            state_d = ST_LOCKOUT;
          end else begin
            tmr_val = TW'(FAIL_CYC);
            state_d = ST_FAIL;
          end
        end
      end
      ST_OPEN, ST_FAIL: begin
        if (tmr_expire) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_expire) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ENTRY_TIMEOUT_EN
    if ((state_q == ST_IDLE || state_q == ST_ENTRY) && (ack_d || err_d)) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(ENTRY_TO_CYC);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      entry_q <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      key_ack <= 1'b0;
      key_err <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      key_ack <= ack_d;
      key_err <= err_d;
    end
  end

  always_comb begin
    entry_mask = '0;
    for (int unsigned i = 0; i < PW_LEN; i++)
      entry_mask[i] = (CW'(i) < cnt_q);
  end

  assign entry_digits = entry_q;
  assign fail_cnt     = fail_q;
  assign unlock       = (state_q == ST_OPEN);
  assign fail_tone    = (state_q == ST_FAIL);
  assign alarm        = (state_q == ST_LOCKOUT);

endmodule
